debounce_edge: RTL and testbench
================================

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 Parameter CNT_W, default 4, width of the accepted-rising-edge event counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port clrn  input  1  reset, asynchronous, active-low.
REQ-005 Port din  input  1  raw asynchronous level, e.g. an inverter output f; may glitch.
REQ-006 Port clr_cnt  input  1  synchronous clear of evt_cnt and ovf.
REQ-007 Port level  output  1  debounced level of din.
REQ-008 Port rise  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-009 Port fall  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-010 Port evt_cnt  output  CNT_W  count of accepted rising edges, saturating.
REQ-011 Port ovf  output  1  sticky flag: a rise occurred while evt_cnt was all-ones.

Function
REQ-012 din SHALL pass through a two-flop synchronizer; the second flop output is s, and only s feeds the FSM.
REQ-013 The FSM SHALL have four states: LOW, CHK_HI, HIGH, CHK_LO.
REQ-014 In LOW, s=1 SHALL go to CHK_HI with timer=1; otherwise it stays in LOW.
REQ-015 In CHK_HI, s=0 SHALL return to LOW with timer=0.
REQ-016 In CHK_HI, s=1 with timer=STABLE_CYCLES-1 SHALL go to HIGH; otherwise timer increments.
REQ-017 HIGH and CHK_LO SHALL mirror REQ-014..016 with s inverted, ending in LOW.
REQ-018 level SHALL be 1 exactly in HIGH and CHK_LO, so no glitch shorter than STABLE_CYCLES samples reaches level.
REQ-019 rise SHALL be 1 for exactly the cycle after the CHK_HI->HIGH transition edge; fall likewise for CHK_LO->LOW. Both are registered and never high together.
REQ-020 Latency: if din is stable 1 from before clock edge k, level and rise SHALL become 1 after edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges; the same holds symmetrically for fall.
REQ-021 evt_cnt SHALL increment by 1 on each rise until all-ones, then hold; a rise at all-ones SHALL set ovf.
REQ-022 clr_cnt=1 SHALL set evt_cnt=0 and ovf=0 on the next edge.
REQ-023 If clr_cnt and rise occur in the same cycle, evt_cnt SHALL become 1 and ovf 0.
REQ-024 timer SHALL be ceil(log2(STABLE_CYCLES)) bits wide and never wrap.

Reset
REQ-025 clrn=0 SHALL immediately force the synchronizer flops, timer, evt_cnt and ovf to 0 and the state to LOW, so level=rise=fall=0, regardless of clk.
REQ-026 Reset asserted mid-qualification SHALL discard the partial count; no rise or fall pulse SHALL be emitted for it.
REQ-027 If din=1 when clrn releases, the block SHALL qualify it normally and emit rise after the REQ-020 latency.

Structure
REQ-028 A shared package SHALL hold the 2-bit state encodings (LOW=00, CHK_HI=01, HIGH=11, CHK_LO=10) and the parameter defaults.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module named sync2, with ports clk, clrn, d and q.

Verification (STABLE_CYCLES=4, CNT_W=4)
REQ-030 Reset, then din 0->1 held -> level=1 and rise=1 for 1 cycle exactly 6 edges after the first edge sampling 1; evt_cnt=1.
REQ-031 din high for 3 cycles, then low -> level stays 0, no rise, evt_cnt unchanged.
REQ-032 Accept high, then din low held -> fall=1 for 1 cycle 6 edges later and level=0; evt_cnt unchanged.
REQ-033 Produce 16 accepted rises -> evt_cnt=15 and ovf=1; then clr_cnt -> evt_cnt=0, ovf=0; clr_cnt coincident with a rise -> evt_cnt=1.
REQ-034 Assert clrn low at timer=2 in CHK_HI while din=1 -> outputs 0 at once and no pulse; after release with din=1 -> rise 6 edges later.

Source files
------------

// File: rtl/debounce_edge_pkg.sv
// Shared definitions for the debounce_edge block: FSM state encodings
// and the default parameter values used by the top module.
package debounce_edge_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b11,
    CHK_LO = 2'b10
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 4;

endpackage

// File: rtl/debounce_edge_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with registered rise/fall pulses and a saturating counter of
// accepted rising edges with a sticky overflow flag.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);

  localparam int unsigned TIMER_W = $clog2(STABLE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  logic               s;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  sync2 u_sync (
    .clk  (clk),
    .clrn (clrn),
    .d    (din),
    .q    (s)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= LOW;
      timer_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The timer counts samples agreeing with the candidate level; the last
  // value is STABLE_CYCLES-1, so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = CHK_HI;
          timer_d = TIMER_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = LOW;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = HIGH;
          timer_d = '0;
          rise_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = CHK_LO;
          timer_d = TIMER_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = HIGH;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = LOW;
          timer_d = '0;
          fall_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      default: begin
        state_d = LOW;
        timer_d = '0;
      end
    endcase
  end

  // A clear coinciding with a visible rise pulse still counts that rise.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_cnt) begin
      cnt_q <= rise_q ? CNT_W'(1) : '0;
      ovf_q <= 1'b0;
    end else if (rise_q) begin
      if (cnt_q == '1) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level   = (state_q == HIGH) || (state_q == CHK_LO);
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign evt_cnt = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed vector table, hand-written
// corner sequences, and randomized runs against a run-length reference model.
module tb_debounce_edge;

  localparam int SC      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int NVEC    = 25;

  logic          clk;
  logic          clrn;
  logic          din;
  logic          clrCnt;
  logic          level;
  logic          rise;
  logic          fall;
  logic [CW-1:0] evtCnt;
  logic          ovf;

  int checkCount;
  int passCount;

  debounce_edge #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .din     (din),
    .clr_cnt (clrCnt),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .evt_cnt (evtCnt),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once SC consecutive synchronized
  // samples (din delayed by two edges) disagree with the current level.
  typedef struct packed {
    logic [1:0]    pipe;
    logic [7:0]    run;
    logic          level;
    logic          rise;
    logic          fall;
    logic          ovf;
    logic [CW-1:0] cnt;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t modelStep(mstate_t cur, logic dinNow, logic clrNow);
    mstate_t nxt;
    logic    sNow;
    nxt      = cur;
    sNow     = cur.pipe[1];
    nxt.pipe = {cur.pipe[0], dinNow};
    if (clrNow) begin
      nxt.cnt = cur.rise ? CW'(1) : CW'(0);
      nxt.ovf = 1'b0;
    end else if (cur.rise) begin
      if (int'(cur.cnt) == CNT_MAX) nxt.ovf = 1'b1;
      else nxt.cnt = cur.cnt + CW'(1);
    end
    nxt.rise = 1'b0;
    nxt.fall = 1'b0;
    if (sNow != cur.level) begin
      if (int'(cur.run) + 1 == SC) begin
        nxt.level = sNow;
        nxt.rise  = sNow;
        nxt.fall  = !sNow;
        nxt.run   = 8'd0;
      end else begin
        nxt.run = cur.run + 8'd1;
      end
    end else begin
      nxt.run = 8'd0;
    end
    return nxt;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) m <= '0;
    else m <= modelStep(m, din, clrCnt);
  end

  typedef struct {
    logic       din;
    logic       clr;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic applyStimulus(input logic d, input logic c);
    din    = d;
    clrCnt = c;
    @(posedge clk);
    #1;
  endtask

  // Expected packing: {level, rise, fall, ovf, evt_cnt[3:0]}
  task automatic checkOutput(input string name, input logic [7:0] expected);
    logic [7:0] actual;
    actual = {level, rise, fall, ovf, evtCnt};
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic acceptPulse();
    repeat (8) applyStimulus(1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic curDin;
    int   runLeft;
    checkCount = 0;
    passCount  = 0;
    clrn   = 1'b0;
    din    = 1'b0;
    clrCnt = 1'b0;

    // Directed table: accepted rise, accepted fall, short glitch, counter clear
    for (int i = 0; i < 5; i++)   vecs[i] = '{1'b1, 1'b0, 8'b0000_0000};
    vecs[5] = '{1'b1, 1'b0, 8'b1100_0000};
    vecs[6] = '{1'b1, 1'b0, 8'b1000_0001};
    for (int i = 7; i < 12; i++)  vecs[i] = '{1'b0, 1'b0, 8'b1000_0001};
    vecs[12] = '{1'b0, 1'b0, 8'b0010_0001};
    vecs[13] = '{1'b0, 1'b0, 8'b0000_0001};
    for (int i = 14; i < 17; i++) vecs[i] = '{1'b1, 1'b0, 8'b0000_0001};
    for (int i = 17; i < 23; i++) vecs[i] = '{1'b0, 1'b0, 8'b0000_0001};
    vecs[23] = '{1'b0, 1'b1, 8'b0000_0000};
    vecs[24] = '{1'b0, 1'b0, 8'b0000_0000};

    #1;
    checkOutput("reset_state", 8'b0000_0000);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clrn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].din, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expected);
    end

    // Saturation and sticky overflow
    for (int n = 1; n <= 16; n++) begin
      acceptPulse();
      if (n == 15) checkOutput("cnt15", 8'b0000_1111);
    end
    checkOutput("ovf_set", 8'b0001_1111);
    applyStimulus(1'b0, 1'b1);
    checkOutput("clr_cnt", 8'b0000_0000);

    // Clear arriving in the same cycle as a rise pulse
    for (int i = 0; i < 12 && rise !== 1'b1; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("coinc_rise", 8'b1100_0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("coinc_clr", 8'b1000_0001);

    // Reset in the middle of qualifying a high level
    repeat (8) applyStimulus(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_reset", 8'b0000_0001);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("reset_async", 8'b0000_0000);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("reset_hold", 8'b0000_0000);
    clrn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("post_reset_edge%0d", i), (i == 6) ? 8'b1100_0000 : 8'b0000_0000);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_cnt", 8'b1000_0001);

    // Randomized runs of varying length against the reference model
    curDin  = 1'b1;
    runLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (runLeft == 0) begin
        curDin  = 1'($urandom_range(0, 1));
        runLeft = $urandom_range(1, 9);
      end
      runLeft--;
      applyStimulus(curDin, ($urandom_range(0, 29) == 0));
      checkOutput($sformatf("random%0d", c), {m.level, m.rise, m.fall, m.ovf, m.cnt});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
